mul_div_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, parametrised in XLEN and bits-per-cycle. It sits beside the single-cycle alu in the execute stage.
- The pipeline issues an M-extension op through a valid/ready handshake and stalls on busy until the result is taken.
- It covers all 8 RV32M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

---
 rtl/mul_div_unit_pkg.sv | 36 +++
 rtl/mul_div_unit_if.sv | 30 +++
 rtl/mul_div_unit_step.sv | 41 ++++
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op codes (RV32M funct3), FSM state encodings, default width and
// small helpers that decide operand signedness per op.
package mul_div_unit_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_a_signed(mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_b_signed(mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide
// unit. The pipeline side uses the master modport, the unit the slave.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) ();

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, A, B, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/mul_div_unit_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: radix-2 shift-add; hi holds the upper partial product and lo
// holds the multiplier, with product bits shifting in from the top.
// Divide: restoring step; hi holds the partial remainder, lo holds the
// dividend shifting out at the top and quotient bits shifting in below.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          ge;

  // Select shift-add or restore-subtract; the remainder after a subtract
  // is always below b, so its low XLEN bits carry the whole value.
  always_comb begin
    sum     = '0;
    shifted = '0;
    ge      = 1'b0;
    hi_out  = '0;
    lo_out  = '0;
    if (is_div) begin
      shifted = {hi_in, lo_in[XLEN-1]};
      ge      = (shifted >= {1'b0, b});
      hi_out  = shifted[XLEN-1:0] - (ge ? b : '0);
      lo_out  = {lo_in[XLEN-2:0], ge};
    end else begin
      sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b} : '0);
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit beside the execute-stage alu.
// Operands are reduced to magnitudes at accept, UNROLL bits are retired
// per CALC cycle through a chain of mdu_step instances, and the sign is
// restored in FIX. Divide-by-zero and signed overflow finish in one edge.
// Optional: define MDU_EARLY_OUT_EN to also finish in one edge for
// multiplies by zero and divides with |A| < |B|.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int UNROLL = 1
) (
  input logic           clk,
  input logic           rstn,
  mul_div_unit_if.slave bus
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;

  mdu_state_e      state;
  mdu_state_e      state_next;
  logic [CW-1:0]   count;
  mdu_op_e         op_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q;

  mdu_op_e         op_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            in_is_div;
  logic            in_is_rem;
  logic            res_neg_in;
  logic            accept;
  logic            special;
  logic [XLEN-1:0] special_result;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  logic [XLEN-1:0] step_hi [UNROLL+1];
  logic [XLEN-1:0] step_lo [UNROLL+1];

  assign op_in      = mdu_op_e'(bus.op);
  assign a_neg      = op_a_signed(op_in) & bus.A[XLEN-1];
  assign b_neg      = op_b_signed(op_in) & bus.B[XLEN-1];
  assign mag_a      = a_neg ? -bus.A : bus.A;
  assign mag_b      = b_neg ? -bus.B : bus.B;
  assign in_is_div  = bus.op[2];
  assign in_is_rem  = bus.op[2] & bus.op[1];
  assign res_neg_in = in_is_rem ? a_neg : (a_neg ^ b_neg);

  assign bus.in_ready  = (state == MDU_IDLE) && !bus.flush;
  assign bus.out_valid = (state == MDU_DONE);
  assign bus.busy      = (state != MDU_IDLE);
  assign bus.result    = result_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // Detect ops whose answer is known at issue and needs no iteration
  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (in_is_div && (bus.B == '0)) begin
      special        = 1'b1;
      special_result = in_is_rem ? bus.A : '1;
    end else if (((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                 (bus.A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.B == '1)) begin
      special        = 1'b1;
      special_result = in_is_rem ? '0 : bus.A;
    end
`ifdef MDU_EARLY_OUT_EN
    else if (!in_is_div && ((bus.A == '0) || (bus.B == '0))) begin
      special        = 1'b1;
      special_result = '0;
    end else if (in_is_div && (mag_a < mag_b)) begin
      special        = 1'b1;
      special_result = in_is_rem ? bus.A : '0;
    end
`endif
  end

  assign step_hi[0] = hi_q;
  assign step_lo[0] = lo_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    mdu_step #(.XLEN(XLEN)) u_step (
      .is_div (op_q[2]),
      .b      (b_q),
      .hi_in  (step_hi[i]),
      .lo_in  (step_lo[i]),
      .hi_out (step_hi[i+1]),
      .lo_out (step_lo[i+1])
    );
  end

  // Restore signs on the finished magnitudes and pick the requested half
  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_fix = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -hi_q : hi_q;
    case (op_q)
      MDU_MUL:                           fix_result = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:   fix_result = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                 fix_result = quot_fix;
      default:                           fix_result = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= MDU_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; flush wins over any accept or result handshake
  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (accept) state_next = special ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (count == CW'(N-1)) state_next = MDU_FIX;
      MDU_FIX:  state_next = MDU_DONE;
      MDU_DONE: if (bus.out_ready) state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
    if (bus.flush) state_next = MDU_IDLE;
  end

  // Datapath: latch magnitudes at accept, iterate in CALC, resolve in FIX
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= '0;
      op_q     <= MDU_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            hi_q  <= '0;
            lo_q  <= mag_a;
            b_q   <= mag_b;
            neg_q <= res_neg_in;
            count <= '0;
            if (special) result_q <= special_result;
          end
        end
        MDU_CALC: begin
          hi_q  <= step_hi[UNROLL];
          lo_q  <= step_lo[UNROLL];
          count <= count + CW'(1);
        end
        MDU_FIX: result_q <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (XLEN=32).
// Expectations for the early-out cases follow MDU_EARLY_OUT_EN.
module tb_mul_div_unit;

  localparam int XLEN     = 32;
  localparam int UNROLL   = 1;
  localparam int NCYC     = XLEN / UNROLL;
  localparam int FULL_LAT = NCYC + 2;
  localparam int MAX_WAIT = 200;
`ifdef MDU_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = FULL_LAT;
`endif

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(XLEN)) bus ();

  mul_div_unit #(.XLEN(XLEN), .UNROLL(UNROLL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Issue one op, scramble the inputs after accept, wait for the result
  // (bounded) and take it. lat counts the accepting edge as edge 1; -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < MAX_WAIT) begin
      @(negedge clk);
      w++;
    end
    bus.op       = o;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = ~o;
    bus.A        = ~a;
    bus.B        = 32'h5A5A_0001;
    lat = 1;
    while (!bus.out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.result;
    if (!bus.out_valid) lat = -1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 00000000", bus.result); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, lat);
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mul_7x-3: got %h expected ffffffeb", r); end
    checks++; if (lat !== FULL_LAT) begin failures++; $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, FULL_LAT); end
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, r, lat);
    checks++; if (r !== 32'h4000_0000) begin failures++; $display("[TB] FAIL mulh_min_min: got %h expected 40000000", r); end
    checks++; if (lat !== FULL_LAT) begin failures++; $display("[TB] FAIL mulh_latency: got %0d expected %0d", lat, FULL_LAT); end
    run_op(OP_MULHU, 32'h8000_0000, 32'h8000_0000, r, lat);
    checks++; if (r !== 32'h4000_0000) begin failures++; $display("[TB] FAIL mulhu: got %h expected 40000000", r); end
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mulhsu_-1x2: got %h expected ffffffff", r); end
    run_op(OP_MUL, 32'h0001_2345, 32'h0000_1000, r, lat);
    checks++; if (r !== 32'h1234_5000) begin failures++; $display("[TB] FAIL mul_shift: got %h expected 12345000", r); end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_-7/2: got %h expected fffffffd", r); end
    checks++; if (lat !== FULL_LAT) begin failures++; $display("[TB] FAIL div_latency: got %0d expected %0d", lat, FULL_LAT); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL rem_-7/2: got %h expected ffffffff", r); end
    run_op(OP_DIVU, 32'd7, 32'd0, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divu_by_zero: got %h expected ffffffff", r); end
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL divu_zero_latency: got %0d expected 1", lat); end
    run_op(OP_REMU, 32'd7, 32'd0, r, lat);
    checks++; if (r !== 32'd7) begin failures++; $display("[TB] FAIL remu_by_zero: got %h expected 00000007", r); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("[TB] FAIL rem_overflow: got %h expected 00000000", r); end
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL rem_overflow_latency: got %0d expected 1", lat); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h8000_0000) begin failures++; $display("[TB] FAIL div_overflow: got %h expected 80000000", r); end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3, r, lat);
    checks++; if (r !== 32'h5555_5555) begin failures++; $display("[TB] FAIL divu_max/3: got %h expected 55555555", r); end
    checks++; if (lat !== FULL_LAT) begin failures++; $display("[TB] FAIL divu_latency: got %0d expected %0d", lat, FULL_LAT); end
  endtask

  task automatic test_backpressure();
    int w;
    w = 0;
    @(negedge clk);
    bus.op = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && w < MAX_WAIT) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_result_arrives: got out_valid %b expected 1", bus.out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.result !== 32'd14) begin failures++; $display("[TB] FAIL bp_result_held: cycle %0d got %h expected 0000000e", i, bus.result); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready_low: cycle %0d got %b expected 0", i, bus.in_ready); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.op = OP_MULHU; bus.A = 32'h8000_0000; bus.B = 32'h8000_0000; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle_after_take: got busy %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_after_take: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_valid_after_take: got %b expected 0", bus.out_valid); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_accept: got busy %b expected 1", bus.busy); end
    w = 0;
    while (!bus.out_valid && w < MAX_WAIT) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++; if (bus.result !== 32'h4000_0000 || bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_result: got %h valid %b expected 40000000 valid 1", bus.result, bus.out_valid); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush_reset();
    logic [31:0] r;
    int lat;
    logic seen;
    @(negedge clk);
    bus.op = OP_MUL; bus.A = 32'd7; bus.B = 32'd9; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    bus.op = OP_DIVU; bus.A = 32'd9; bus.B = 32'd0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_blocks_accept: got busy %b valid %b expected 0 0", bus.busy, bus.out_valid); end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_release_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    bus.op = OP_DIV; bus.A = 32'd1000; bus.B = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midcalc_reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midcalc_reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midcalc_reset_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (NCYC + 6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL no_spurious_result: got activity %b expected 0", seen); end
    run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) begin failures++; $display("[TB] FAIL divu_100/7: got %h expected 0000000e", r); end
    checks++; if (lat !== FULL_LAT) begin failures++; $display("[TB] FAIL divu_100/7_latency: got %0d expected %0d", lat, FULL_LAT); end
  endtask

  task automatic test_early_out();
    logic [31:0] r;
    int lat;
    run_op(OP_DIVU, 32'd3, 32'd5, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("[TB] FAIL divu_3/5: got %h expected 00000000", r); end
    checks++; if (lat !== EARLY_LAT) begin failures++; $display("[TB] FAIL divu_3/5_latency: got %0d expected %0d", lat, EARLY_LAT); end
    run_op(OP_REM, 32'hFFFF_FFFD, 32'd5, r, lat);
    checks++; if (r !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL rem_-3/5: got %h expected fffffffd", r); end
    checks++; if (lat !== EARLY_LAT) begin failures++; $display("[TB] FAIL rem_-3/5_latency: got %0d expected %0d", lat, EARLY_LAT); end
    run_op(OP_DIV, 32'hFFFF_FFFD, 32'd5, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("[TB] FAIL div_-3/5: got %h expected 00000000", r); end
    run_op(OP_MUL, 32'h0000_1234, 32'h0, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("[TB] FAIL mul_by_zero: got %h expected 00000000", r); end
    checks++; if (lat !== EARLY_LAT) begin failures++; $display("[TB] FAIL mul_by_zero_latency: got %0d expected %0d", lat, EARLY_LAT); end
    run_op(OP_REMU, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd2) begin failures++; $display("[TB] FAIL remu_100/7: got %h expected 00000002", r); end
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_backpressure();
    test_flush_reset();
    test_early_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
